lpset_crc: RTL and testbench
============================

LPSET_CRC -- requirements
Module: lpset_crc

Interface
REQ-001 Parameter N_BITS, default 48: number of serial message bits processed per run; legal range 1..65535.
REQ-002 Parameter POLY, default 16'h8005: generator polynomial x^16+x^15+x^2+1, with the x^16 term implicit.
REQ-003 Parameter INIT, default 16'h0000: value loaded into r on start.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: one-cycle pulse that begins a new CRC run.
REQ-007 Port data, input, 1 bit: serial message bit, MSB first, sampled on each rising edge while busy.
REQ-008 Port done, output, 1 bit: high once N_BITS bits have been absorbed.
REQ-009 Port r, output, 16 bits: CRC remainder register.

Function
REQ-010 The block SHALL have the states IDLE and BUSY, with the bit counter held in a 16-bit register.
- IDLE + start=1 -> BUSY; r<=INIT, count<=0, done<=0.
- BUSY -> IDLE when count reaches N_BITS.
REQ-011 The block SHALL ignore data on the edge that samples start=1; the first message bit is sampled on the next rising edge.
REQ-012 Each BUSY edge SHALL apply the bit update: fb = data ^ r[15]; r <= {r[14:0],1'b0} ^ (fb ? POLY : 0); count <= count+1.
- Form: Galois, non-reflected, no augmentation, no final XOR.
REQ-013 On the edge that absorbs bit N_BITS, done SHALL rise, so done is high in the cycle after the last data sample.
REQ-014 After the run, done SHALL stay high and r SHALL hold its value until the next start.
REQ-015 A start in BUSY SHALL abort the current run and restart as in REQ-010; the aborted run never raises done.
REQ-016 In IDLE, data SHALL be ignored and r and done SHALL hold.
REQ-017 Appending the message's own CRC, MSB first, SHALL give r=0.

Reset
REQ-018 reset_n=0 SHALL immediately force state=IDLE, r=16'h0000, done=0 and count=0, regardless of clock.
REQ-019 Reset asserted mid-run SHALL discard the run; after release, a start is required before done rises.
REQ-020 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Configuration
REQ-021 With macro LPSET_CRC_CHECK_EN defined, the block SHALL add an output port crc_ok, 1 bit.
- crc_ok = done & (r==16'h0000).
- crc_ok resets to 0.
REQ-022 Without LPSET_CRC_CHECK_EN, the crc_ok port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-023 A shared package lpset_crc_pkg SHALL hold:
- the state enum (IDLE, BUSY);
- CRC_W=16;
- default constants CRC16_POLY=16'h8005 and CRC16_INIT=16'h0000.
REQ-024 The per-bit update SHALL be one sub-module, crc16_step, which is purely combinational.
- Inputs: r_in, data, POLY.
- Output: r_out.
REQ-025 lpset_crc SHALL hold only the FSM, the counter and the registers.

Verification
REQ-026 Nominal run: reset, then a start pulse, then bits of 48'h03_01_02_03_30_3A MSB first, one per clock from the edge after start -> done rises the cycle after bit 48; r=16'h00D8.
REQ-027 Self-check: message 32'h03_01_02_03 with N_BITS=32 -> r=16'h301E. Then stream 48'h03_01_02_03_30_1E with N_BITS=48 -> r=16'h0000, and crc_ok=1 when LPSET_CRC_CHECK_EN is defined.
REQ-028 All-zero data, 48 bits, INIT=0 -> r=16'h0000 and done=1; done and r hold for 20 idle cycles despite data toggling.
REQ-029 Restart: start again at bit 20 of a run, then stream the full vector from REQ-026 -> done rises once, 48 bits after the second start; r=16'h00D8.
REQ-030 Async reset: assert reset_n=0 between clock edges at bit 30 -> r=0 and done=0 immediately. After release, done stays 0 with no start; a new full run gives r=16'h00D8.
REQ-031 Single bit: data=1 as the first bit, followed by 47 zeros -> r equals the 16-bit value obtained by applying REQ-012 to that stream (reference-model compare).

Source files
------------

// File: rtl/lpset_crc_pkg.sv
// Shared types and constants for the serial CRC-16 engine.
package lpset_crc_pkg;

    localparam int unsigned CRC_W = 16;
    localparam int unsigned CNT_W = 16;

    localparam logic [CRC_W-1:0] CRC16_POLY = 16'h8005;
    localparam logic [CRC_W-1:0] CRC16_INIT = 16'h0000;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/crc16_step.sv
// One-bit Galois CRC-16 update: non-reflected, MSB-first, no augmentation.
module crc16_step
    import lpset_crc_pkg::*;
(
    input  logic [CRC_W-1:0] r_in,
    input  logic             data,
    input  logic [CRC_W-1:0] poly,
    output logic [CRC_W-1:0] r_out
);

    logic fb;

    always_comb begin
        fb    = data ^ r_in[CRC_W-1];
        r_out = {r_in[CRC_W-2:0], 1'b0} ^ (fb ? poly : {CRC_W{1'b0}});
    end

endmodule

// File: rtl/lpset_crc.sv
// Serial CRC-16 engine: absorbs N_BITS message bits per start pulse.
// Define LPSET_CRC_CHECK_EN to add the registered crc_ok (zero-remainder) flag.
module lpset_crc
    import lpset_crc_pkg::*;
#(
    parameter int unsigned      N_BITS = 48,
    parameter logic [CRC_W-1:0] POLY   = CRC16_POLY,
    parameter logic [CRC_W-1:0] INIT   = CRC16_INIT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             data,
    output logic             done,
`ifdef LPSET_CRC_CHECK_EN
    output logic             crc_ok,
`endif
    output logic [CRC_W-1:0] r
);

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [CRC_W-1:0] r_n;
    logic [CRC_W-1:0] r_step;
    logic             done_n;

    crc16_step u_step (
        .r_in  (r),
        .data  (data),
        .poly  (POLY),
        .r_out (r_step)
    );

    // Next-state: start always (re)launches a run, even mid-run.
    always_comb begin
        state_n = state;
        count_n = count;
        r_n     = r;
        done_n  = done;
        if (start) begin
            state_n = BUSY;
            count_n = '0;
            r_n     = INIT;
            done_n  = 1'b0;
        end else if (state == BUSY) begin
            r_n     = r_step;
            count_n = count + CNT_W'(1);
            if (count_n == CNT_W'(N_BITS)) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            r     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            r     <= r_n;
            done  <= done_n;
        end
    end

`ifdef LPSET_CRC_CHECK_EN
    // Registered from next-state values so it tracks done/r in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_ok <= 1'b0;
        end else begin
            crc_ok <= done_n & (r_n == '0);
        end
    end
`endif

endmodule

// File: tb/tb_lpset_crc.sv
// Scoreboard bench for lpset_crc: 48-bit and 32-bit instances share data.
module tb_lpset_crc;

    logic        clock;
    logic        reset_n;
    logic        start48, start32;
    logic        data;
    logic        done48, done32;
    logic [15:0] r48, r32;
`ifdef LPSET_CRC_CHECK_EN
    logic        ok48, ok32;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [15:0] exp_r;
    } exp_t;

    exp_t sb[$];

    lpset_crc #(.N_BITS(48)) u48 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start48),
        .data    (data),
        .done    (done48),
`ifdef LPSET_CRC_CHECK_EN
        .crc_ok  (ok48),
`endif
        .r       (r48)
    );

    lpset_crc #(.N_BITS(32)) u32 (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start32),
        .data    (data),
        .done    (done32),
`ifdef LPSET_CRC_CHECK_EN
        .crc_ok  (ok32),
`endif
        .r       (r32)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference bit-serial CRC: MSB-first Galois update from init.
    function automatic logic [15:0] crc_model(input logic [47:0] msg, input int nbits,
                                              input logic [15:0] init);
        logic [15:0] c = init;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (msg[i] ^ c[15]) c = (c << 1) ^ 16'h8005;
            else                c = c << 1;
        end
        return c;
    endfunction

    function automatic logic sel_done(input int sel);
        return (sel == 32) ? done32 : done48;
    endfunction

    function automatic logic [15:0] sel_r(input int sel);
        return (sel == 32) ? r32 : r48;
    endfunction

    task automatic pulse_start(input int sel);
        if (sel == 32) start32 = 1'b1; else start48 = 1'b1;
        @(negedge clock);
        start32 = 1'b0;
        start48 = 1'b0;
    endtask

    // Drive nbits of msg (low-aligned, MSB first); the bit before each posedge is absorbed there.
    task automatic feed(input int sel, input logic [47:0] msg, input int nbits, input string tag);
        for (int i = nbits - 1; i >= 0; i--) begin
            data = msg[i];
            if (i == 0) check({tag, "_done_early"}, 32'(sel_done(sel)), 32'd0);
            @(negedge clock);
        end
        data = 1'b0;
    endtask

    task automatic run(input int sel, input logic [47:0] msg, input int nbits,
                       input logic [15:0] exp_r, input string tag);
        exp_t e;
        int   k;
        sb.push_back('{tag, exp_r});
        pulse_start(sel);
        feed(sel, msg, nbits, tag);
        k = 0;
        while (!sel_done(sel) && k < 4) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_done_latency"}, 32'(k), 32'd0);
        check({tag, "_done"}, 32'(sel_done(sel)), 32'd1);
        e = sb.pop_front();
        check({e.tag, "_r"}, 32'(sel_r(sel)), 32'(e.exp_r));
    endtask

    initial begin
        reset_n = 1'b0;
        start48 = 1'b0;
        start32 = 1'b0;
        data    = 1'b0;
        #12;
        check("rst_r48", 32'(r48), 32'd0);
        check("rst_done48", 32'(done48), 32'd0);
        check("rst_r32", 32'(r32), 32'd0);
        check("rst_done32", 32'(done32), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        run(48, 48'h03_01_02_03_30_3A, 48, 16'h00D8, "nominal");
        run(32, 48'h0000_03_01_02_03, 32, 16'h301E, "msg32");
        run(48, 48'h03_01_02_03_30_1E, 48, 16'h0000, "selfchk");
`ifdef LPSET_CRC_CHECK_EN
        check("selfchk_crc_ok", 32'(ok48), 32'd1);
        check("nominal32_crc_ok", 32'(ok32), 32'd0);
`endif

        run(48, 48'h0, 48, 16'h0000, "zeros");
        // A non-zero remainder makes the idle-hold check meaningful.
        run(48, 48'h03_01_02_03_30_3A, 48, 16'h00D8, "prehold");
        for (int i = 0; i < 20; i++) begin
            data = 1'($urandom_range(0, 1)) ^ 1'(i);
            @(negedge clock);
            if (i == 19 || done48 !== 1'b1 || r48 !== 16'h00D8) begin
                check("hold_done", 32'(done48), 32'd1);
                check("hold_r", 32'(r48), 32'h00D8);
            end
        end

        // Restart mid-run at bit 20.
        pulse_start(48);
        feed(48, 48'hFF_FF_F0_00_00_00, 20, "abort");
        check("abort_done", 32'(done48), 32'd0);
        run(48, 48'h03_01_02_03_30_3A, 48, 16'h00D8, "restart");

        // Async reset between edges at bit 30.
        pulse_start(48);
        feed(48, 48'h03_01_02_03_30_3A >> 18, 30, "areset");
        check("areset_r_before", 32'(r48 != 16'h0), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("areset_r", 32'(r48), 32'd0);
        check("areset_done", 32'(done48), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            data = 1'(i);
            @(negedge clock);
        end
        check("areset_no_start_done", 32'(done48), 32'd0);
        run(48, 48'h03_01_02_03_30_3A, 48, 16'h00D8, "post_reset");

        run(48, 48'h80_00_00_00_00_00, 48, crc_model(48'h80_00_00_00_00_00, 48, 16'h0000),
            "single_bit");
        run(48, 48'hA5_5A_C3_3C_0F_F0, 48, crc_model(48'hA5_5A_C3_3C_0F_F0, 48, 16'h0000),
            "pattern");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
